// File: rtl/fram_port_arbiter.sv
// ---------------------------------------------------------------------------
// fram_port_arbiter
//   Shares the single 16-bit-word SPI FRAM port between two requesters:
//   port 0 (SUBLEQ core fetch/exec) and port 1 (loader/debug). One
//   transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in WAIT before the transaction is aborted
//   FIXED_PRIO      0 = round-robin on ties, 1 = port 0 always wins ties
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   rN_req/rN_we/rN_addr/rN_wdata   requester N command (level, held to ack)
//   rN_ack                          one-cycle completion pulse to requester N
//   rN_rdata                        read data, held until the next read ack
//   mem_addr/mem_data_in/mem_we     latched command to the FRAM interface
//   mem_start                       one-cycle start pulse (ISSUE state)
//   mem_data_out/mem_done           read data / completion from the FRAM
//   busy                            high in every state except IDLE
//   timeout                         sticky abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module fram_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter bit FIXED_PRIO     = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [15:0] r0_addr,
   input  logic [15:0] r0_wdata,
   output logic        r0_ack,
   output logic [15:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [15:0] r1_addr,
   input  logic [15:0] r1_wdata,
   output logic        r1_ack,
   output logic [15:0] r1_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   output logic        mem_we,
   output logic        mem_start,
   input  logic [15:0] mem_data_out,
   input  logic        mem_done,
   output logic        busy,
   output logic        timeout
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               grant_q;       // port owning the current transaction
   logic               last_grant_q;  // port granted most recently
   logic               win_port;      // port that would be granted this cycle
   logic               tie;
   logic               mem_we_q;
   logic [15:0]        mem_addr_q;
   logic [15:0]        mem_data_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               timeout_q;
   logic [15:0]        r0_rdata_q, r1_rdata_q;

   // NOTE: every signal written here gets a default before the case, so no
   // path through the block can leave a value unassigned and infer a latch.
   always_comb begin
      tie      = r0_req & r1_req;
      win_port = r1_req;
      if (tie) begin
         // Round-robin hands a tie to the port that did not win last time.
         win_port = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      end

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (r0_req || r1_req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (mem_done || (cnt_q == CNT_LAST)) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;  // port 0 wins the first tie after reset
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 16'h0000;
         mem_data_q   <= 16'h0000;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         r0_rdata_q   <= 16'h0000;
         r1_rdata_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (r0_req || r1_req) begin
                  grant_q      <= win_port;
                  last_grant_q <= win_port;
                  mem_we_q     <= win_port ? r1_we    : r0_we;
                  mem_addr_q   <= win_port ? r1_addr  : r0_addr;
                  mem_data_q   <= win_port ? r1_wdata : r0_wdata;
               end
            end
            ST_ISSUE: cnt_q <= '0;
            ST_WAIT: begin
               // A done in the last counted cycle beats the timeout.
               if (mem_done) begin
                  if (!mem_we_q) begin
                     if (grant_q) r1_rdata_q <= mem_data_out;
                     else         r0_rdata_q <= mem_data_out;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  timeout_q <= 1'b1;
                  if (!mem_we_q) begin
                     if (grant_q) r1_rdata_q <= 16'h0000;
                     else         r0_rdata_q <= 16'h0000;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Pulses decode directly from the state register, so they are glitch-free
   // and all read 0 while in reset.
   assign mem_start   = (state_q == ST_ISSUE);
   assign busy        = (state_q != ST_IDLE);
   assign r0_ack      = (state_q == ST_RESP) && !grant_q;
   assign r1_ack      = (state_q == ST_RESP) &&  grant_q;
   assign r0_rdata    = r0_rdata_q;
   assign r1_rdata    = r1_rdata_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_q;
   assign mem_we      = mem_we_q;
   assign timeout     = timeout_q;

endmodule
